alu_muldiv_seq: RTL and testbench

- Multi-cycle sequencer that computes MUL, MULHU, DIVU and REMU by driving the core's existing 32-bit ALU with one ADD or SUB per cycle.
- Uses shift-add for multiply and restoring division for divide.
- Sits beside the ALU in the execute stage; the ALU operand/op mux selects this block's outputs while o_busy is high.

---
 rtl/alu_muldiv_seq.sv | 121 ++++++++++++
 tb/tb_alu_muldiv_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MUL/MULHU/DIVU/REMU sequencer that borrows the execute-stage ALU
// for one ADD (shift-add multiply) or SUB (restoring divide) per cycle.
module alu_muldiv_seq (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic        i_flush,
  output logic [31:0] o_alu_operand_a,
  output logic [31:0] o_alu_operand_b,
  output logic [3:0]  o_alu_op,
  input  logic [31:0] i_alu_data,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_result
);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned CNT_W    = 5;
  localparam logic [3:0]  ALU_ADD  = 4'b0000;
  localparam logic [3:0]  ALU_SUB  = 4'b1000;
  localparam logic [1:0]  OP_MUL   = 2'b00;
  localparam logic [1:0]  OP_MULHU = 2'b01;
  localparam logic [1:0]  OP_DIVU  = 2'b10;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q;
  logic [1:0]        op_q;
  // acc: hi (multiply) / r (divide); sh: lo / q; opnd: mcand / dvs
  logic [XLEN-1:0]   acc_q, sh_q, opnd_q;
  logic              is_div;
  logic [XLEN:0]     div_sh;
  logic              mul_carry, div_ge;
  logic              start_ok, step_ok;

  assign is_div    = op_q[1];
  assign div_sh    = {acc_q, sh_q[XLEN-1]};
  assign mul_carry = (i_alu_data < acc_q);
  assign div_ge    = div_sh[XLEN] | (div_sh[XLEN-1:0] >= opnd_q);
  assign start_ok  = (state_q == IDLE) && i_start && !i_flush;
  assign step_ok   = (state_q == RUN) && !i_flush;
  assign o_busy    = (state_q != IDLE);

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state, ALU drive and result strobe
  always_comb begin
    state_d         = state_q;
    o_alu_operand_a = '0;
    o_alu_operand_b = '0;
    o_alu_op        = ALU_ADD;
    o_done          = 1'b0;
    o_result        = '0;
    case (state_q)
      IDLE: begin
        if (start_ok) state_d = RUN;
      end
      RUN: begin
        if (is_div) begin
          o_alu_operand_a = div_sh[XLEN-1:0];
          o_alu_operand_b = opnd_q;
          o_alu_op        = ALU_SUB;
        end else begin
          o_alu_operand_a = acc_q;
          o_alu_operand_b = sh_q[0] ? opnd_q : '0;
        end
        if (i_flush)                           state_d = IDLE;
        else if (count_q == CNT_W'(XLEN - 1))  state_d = DONE;
      end
      DONE: begin
        // A flush landing on the DONE cycle suppresses the strobe
        o_done = !i_flush;
        if (!i_flush) begin
          case (op_q)
            OP_MUL:   o_result = sh_q;
            OP_MULHU: o_result = acc_q;
            OP_DIVU:  o_result = sh_q;
            default:  o_result = acc_q;
          endcase
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand latch on start, one shift-add / restore step per RUN cycle
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_q <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      opnd_q  <= '0;
    end else if (start_ok) begin
      count_q <= '0;
      op_q    <= i_op;
      acc_q   <= '0;
      sh_q    <= i_rs1;
      opnd_q  <= i_rs2;
    end else if (step_ok) begin
      count_q <= count_q + CNT_W'(1);
      if (is_div) begin
        acc_q <= div_ge ? i_alu_data : div_sh[XLEN-1:0];
        sh_q  <= {sh_q[XLEN-2:0], div_ge};
      end else begin
        acc_q <= {mul_carry, i_alu_data[XLEN-1:1]};
        sh_q  <= {i_alu_data[0], sh_q[XLEN-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed and random operations
// against a plain-arithmetic reference, with a behavioural ALU stub.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1, rs2;
  logic        flush;
  logic [31:0] alu_a, alu_b, alu_data, result;
  logic [3:0]  alu_op;
  logic        busy, done;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  // The core ALU: only ADD and SUB are ever requested
  assign alu_data = (alu_op == 4'b1000) ? (alu_a - alu_b) : (alu_a + alu_b);

  alu_muldiv_seq dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_start         (start),
    .i_op            (op),
    .i_rs1           (rs1),
    .i_rs2           (rs2),
    .i_flush         (flush),
    .o_alu_operand_a (alu_a),
    .o_alu_operand_b (alu_b),
    .o_alu_op        (alu_op),
    .i_alu_data      (alu_data),
    .o_busy          (busy),
    .o_done          (done),
    .o_result        (result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (o)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},   {31'b0, busy},   32'h0);
    check({tag, "_done"},   {31'b0, done},   32'h0);
    check({tag, "_result"}, result,          32'h0);
    check({tag, "_alu_a"},  alu_a,           32'h0);
    check({tag, "_alu_b"},  alu_b,           32'h0);
    check({tag, "_alu_op"}, {28'b0, alu_op}, 32'h0);
  endtask

  // Run one operation; operands are scrambled after the start edge to prove latching
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    int busy_cycles;
    int done_at;
    logic [31:0] exp_res;
    logic [31:0] exp_aluop;
    exp_res   = model(o, a, b);
    exp_aluop = o[1] ? 32'h8 : 32'h0;
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); rs1 = $urandom; rs2 = $urandom;
    busy_cycles = 0;
    done_at = 0;
    while (busy && busy_cycles < 40) begin
      busy_cycles++;
      if (done) begin
        done_at = busy_cycles;
        check({tag, "_result"}, result, exp_res);
        check({tag, "_done_aluab"}, alu_a | alu_b, 32'h0);
        check({tag, "_done_aluop"}, {28'b0, alu_op}, 32'h0);
      end else begin
        check({tag, "_run_aluop"}, {28'b0, alu_op}, exp_aluop);
      end
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd33);
    check({tag, "_done_cycle"}, 32'(done_at), 32'd33);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle");

    do_op(2'b00, 32'd7, 32'd6, "mul_7x6");
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
    do_op(2'b10, 32'd100, 32'd7, "divu_100_7");
    do_op(2'b11, 32'd100, 32'd7, "remu_100_7");
    do_op(2'b10, 32'hFFFF_FFFF, 32'h8000_0001, "divu_sh32");
    do_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, "remu_sh32");
    do_op(2'b10, 32'h1234_5678, 32'h0, "divu_by0");
    do_op(2'b11, 32'h1234_5678, 32'h0, "remu_by0");
    do_op(2'b00, 32'h1234_5678, 32'h0, "mul_by0");

    // Flush mid-run, with an ignored start at RUN cycle 4
    @(negedge clk);
    start = 1'b1; op = 2'b00; rs1 = 32'd3; rs2 = 32'd5;
    @(posedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      start = (c == 4);
      flush = (c == 9);
      check("flush_run_busy", {31'b0, busy}, 32'h1);
      check("flush_run_done", {31'b0, done}, 32'h0);
    end
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_after", {31'b0, busy}, 32'h0);
    check("flush_done_after", {31'b0, done}, 32'h0);
    repeat (2) @(negedge clk);
    check("flush_no_queue", {31'b0, busy}, 32'h0);
    do_op(2'b10, 32'd9, 32'd2, "divu_9_2");

    // Flush in IDLE beats start
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("idle_flush_prio", {31'b0, busy}, 32'h0);

    // Asynchronous reset in the middle of a RUN cycle
    start = 1'b1; op = 2'b00; rs1 = 32'd11; rs2 = 32'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_idle_outputs("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) check("rst_no_resume", {30'b0, busy, done}, 32'h0);
    end
    check("rst_idle", {31'b0, busy}, 32'h0);
    do_op(2'b00, 32'd2, 32'd3, "mul_2x3");

    // Random operations against the arithmetic reference
    for (int i = 0; i < 12; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom);
      ra = $urandom;
      rb = (i % 4 == 3) ? (32'($urandom) >> 20) : 32'($urandom);
      do_op(ro, ra, rb, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
